data_buffer: RTL

DATA_BUFFER -- requirements
Module: data_buffer

---
 rtl/data_buffer.sv | 84 ++++++++
 1 files changed

// File: rtl/data_buffer.sv
// First-word fall-through data buffer with flush and a saturating push counter.
// Power-of-two depth lets the read and write pointers wrap naturally.
module data_buffer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [CNT_WIDTH-1:0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    if (WIDTH == 0) begin : g_bad_width
        $error("data_buffer: WIDTH must be non-zero");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("data_buffer: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;
    logic [CNT_WIDTH-1:0] count;
    logic                 push;
    logic                 pop;

    assign ready_o = !rst_i && (level < FULL);
    assign valid_o = (level != '0);
    assign data_o  = mem[rd_ptr];
    assign level_o = level;
    assign count_o = count;

    // ready_o already folds in rst_i, so no write lands during reset
    assign push = valid_i && ready_o && !flush_i;
    assign pop  = valid_o && ready_i && !flush_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && count != '1) begin
                count <= count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
